// File: rtl/pipe_pkg.sv
// pipe_pkg: shared MDU op codes, latencies, EPC register number and MDU FSM state encoding
package pipe_pkg;
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_MULT = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;
  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC = 4'd10;
  localparam logic [4:0] EPC_REG = 5'd14;
  typedef enum logic {IDLE, BUSY} mdu_state_e;
endpackage

// File: rtl/mdu_busy_fsm.sv
// mdu_busy_fsm: MDU occupancy tracker; in clk, reset (async active-low), req, mdu_op[1:0]; out busy
module mdu_busy_fsm
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] mdu_op,
  output logic       busy
);
  mdu_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic start;
  always_comb begin
    start = state_q == IDLE && !req && (mdu_op == OP_MULT || mdu_op == OP_DIV);
    state_d = start ? BUSY : (state_q == BUSY && cnt_q == 4'd1) ? IDLE : state_q;
    cnt_d = start ? (mdu_op == OP_DIV ? DIV_CYC : MULT_CYC) : state_q == BUSY ? cnt_q - 4'd1 : cnt_q;
    busy = state_q == BUSY || start;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush control; hazard inputs from D/E/M, Req, MDU op; outputs StallF/D/E, FlushD/M/W, Busy; option PIPE_CTRL_ERET_HAZARD_EN
module pipe_ctrl
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       Req,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [1:0] Tuse_rsD,
  input  logic [1:0] Tuse_rtD,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [1:0] TnewE,
  input  logic [1:0] TnewM,
  input  logic [1:0] mdu_opE,
  input  logic       mdu_useD,
  input  logic       eretD,
  input  logic       CP0WriteE,
  input  logic       CP0WriteM,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushM,
  output logic       FlushW,
  output logic       Busy
);
  logic haz_rs, haz_rt, haz_eret, stall;
  mdu_busy_fsm u_mdu (.clk(clk), .reset(reset), .req(Req), .mdu_op(mdu_opE), .busy(Busy));
  assign haz_rs = RsD != 5'd0 && ((RegWriteE && WriteRegE == RsD && TnewE > Tuse_rsD) || (RegWriteM && WriteRegM == RsD && TnewM > Tuse_rsD));
  assign haz_rt = RtD != 5'd0 && ((RegWriteE && WriteRegE == RtD && TnewE > Tuse_rtD) || (RegWriteM && WriteRegM == RtD && TnewM > Tuse_rtD));
`ifdef PIPE_CTRL_ERET_HAZARD_EN
  assign haz_eret = eretD && ((CP0WriteE && RdE == EPC_REG) || (CP0WriteM && RdM == EPC_REG));
`else
  logic unused_eret;
  assign unused_eret = ^{eretD, CP0WriteE, CP0WriteM, RdE, RdM};
  assign haz_eret = 1'b0;
`endif
  assign stall = (haz_rs || haz_rt || (mdu_useD && Busy) || haz_eret) && !Req;
  assign StallF = stall;
  assign StallD = stall;
  assign StallE = stall;
  assign FlushD = Req;
  assign FlushM = Req;
  assign FlushW = Req;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl against a cycle-timeline model
module tb_pipe_ctrl;
  logic clk = 0, reset = 0, Req = 0;
  logic [4:0] RsD = 0, RtD = 0, WriteRegE = 0, WriteRegM = 0, RdE = 0, RdM = 0;
  logic [1:0] Tuse_rsD = 0, Tuse_rtD = 0, TnewE = 0, TnewM = 0, mdu_opE = 0;
  logic RegWriteE = 0, RegWriteM = 0, mdu_useD = 0, eretD = 0, CP0WriteE = 0, CP0WriteM = 0;
  logic StallF, StallD, StallE, FlushD, FlushM, FlushW, Busy;
  int passed = 0, total = 0, cyc = 0, busy_until = -1;
  always #5 clk = ~clk;
  pipe_ctrl dut (
    .clk(clk), .reset(reset), .Req(Req), .RsD(RsD), .RtD(RtD), .Tuse_rsD(Tuse_rsD), .Tuse_rtD(Tuse_rtD),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
    .TnewE(TnewE), .TnewM(TnewM), .mdu_opE(mdu_opE), .mdu_useD(mdu_useD), .eretD(eretD),
    .CP0WriteE(CP0WriteE), .CP0WriteM(CP0WriteM), .RdE(RdE), .RdM(RdM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushM(FlushM), .FlushW(FlushW), .Busy(Busy)
  );
  function automatic bit src_haz(input logic [4:0] r, input logic [1:0] tuse);
    if (r == 0) return 0;
    return (RegWriteE && WriteRegE == r && TnewE > tuse) || (RegWriteM && WriteRegM == r && TnewM > tuse);
  endfunction
  function automatic bit op_valid();
    return (mdu_opE == 2'd1 || mdu_opE == 2'd2) && !Req;
  endfunction
  function automatic bit exp_busy();
    return cyc <= busy_until || op_valid();
  endfunction
  function automatic bit exp_eret();
`ifdef PIPE_CTRL_ERET_HAZARD_EN
    return eretD && ((CP0WriteE && RdE == 14) || (CP0WriteM && RdM == 14));
`else
    return 0;
`endif
  endfunction
  function automatic bit exp_stall();
    return !Req && (src_haz(RsD, Tuse_rsD) || src_haz(RtD, Tuse_rtD) || (mdu_useD && exp_busy()) || exp_eret());
  endfunction
  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask
  task automatic verify(input string tag);
    check({tag, " stall"}, {StallF, StallD, StallE}, {3{exp_stall()}});
    check({tag, " flush"}, {FlushD, FlushM, FlushW}, {3{Req}});
    check({tag, " busy"}, {2'b0, Busy}, {2'b0, exp_busy()});
  endtask
  task automatic step(input string tag);
    #4 verify(tag);
    @(posedge clk);
    if (cyc > busy_until && op_valid()) busy_until = cyc + (mdu_opE == 2'd1 ? 5 : 10);
    cyc++;
    #1;
  endtask
  task automatic clear();
    {Req, RsD, RtD, WriteRegE, WriteRegM, RdE, RdM} = '0;
    {Tuse_rsD, Tuse_rtD, TnewE, TnewM, mdu_opE} = '0;
    {RegWriteE, RegWriteM, mdu_useD, eretD, CP0WriteE, CP0WriteM} = '0;
  endtask
  initial begin
    #3 verify("reset");
    @(posedge clk);
    #1 reset = 1;
    RegWriteE = 1; WriteRegE = 8; TnewE = 2; RsD = 8; Tuse_rsD = 0;
    step("raw_e");
    TnewE = 0;
    step("raw_e_ready");
    clear(); RegWriteM = 1; WriteRegM = 9; TnewM = 2; RtD = 9; Tuse_rtD = 1;
    step("raw_m_rt");
    clear(); RegWriteE = 1; WriteRegE = 0; TnewE = 2; RsD = 0;
    step("zero_reg");
    clear(); mdu_opE = 1; mdu_useD = 1;
    step("mult_t");
    mdu_opE = 0;
    repeat (5) step("mult_busy");
    step("mult_done");
    clear(); mdu_opE = 2;
    step("div_t");
    mdu_opE = 0;
    repeat (2) step("div_busy");
    mdu_opE = 1;
    step("div_ignore");
    mdu_opE = 0; mdu_useD = 1;
    repeat (7) step("div_busy2");
    step("div_done");
    clear(); Req = 1; RegWriteE = 1; WriteRegE = 8; TnewE = 2; RsD = 8; mdu_opE = 1; mdu_useD = 1;
    step("req_prio");
    clear();
    step("req_idle");
    mdu_opE = 2;
    step("rst_div_t");
    mdu_opE = 0;
    repeat (4) step("rst_div_busy");
    #2 reset = 0;
    busy_until = -1;
    #1 verify("async_rst");
    reset = 1;
    step("after_rst");
    clear(); eretD = 1; CP0WriteM = 1; RdM = 14;
    step("eret_m");
    RdM = 13; CP0WriteE = 1; RdE = 14;
    step("eret_e");
    clear();
    for (int i = 0; i < 400; i++) begin
      Req = $urandom_range(0, 15) == 0;
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      Tuse_rsD = 2'($urandom); Tuse_rtD = 2'($urandom); TnewE = 2'($urandom); TnewM = 2'($urandom);
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom);
      mdu_opE = $urandom_range(0, 5) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
      mdu_useD = 1'($urandom); eretD = 1'($urandom); CP0WriteE = 1'($urandom); CP0WriteM = 1'($urandom);
      RdE = $urandom_range(0, 1) == 0 ? 5'd14 : 5'd13; RdM = $urandom_range(0, 1) == 0 ? 5'd14 : 5'd12;
      step("random");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
